// File: rtl/set_assoc_cache.sv
// Set-associative write-back cache with true-LRU replacement.
// One WIDTH-bit word per line. A hit is answered on the cycle after it is
// accepted. A miss optionally writes back a dirty victim, refills the line,
// then answers from the RESPOND state.
module set_assoc_cache #(
    parameter int WIDTH = 32,
    parameter int SETS  = 16,
    parameter int WAYS  = 4,
    parameter int B     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [WIDTH-1:0] req_addr_i,
    input  logic [WIDTH-1:0] req_wdata_i,
    output logic             resp_valid_o,
    output logic             resp_hit_o,
    output logic [WIDTH-1:0] resp_rdata_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic             mem_ack_i,
    input  logic [WIDTH-1:0] mem_rdata_i,
    output logic [31:0]      stat_hits_o,
    output logic [31:0]      stat_misses_o
);

    localparam int OFF_W = $clog2(B);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WIDTH - OFF_W - IDX_W;
    localparam int AW    = $clog2(WAYS);

    typedef logic [WAYS-1:0][AW-1:0] age_vec_t;
    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_t;

    // Control state (reset)
    state_t            state_q;
    logic              resp_valid_q;
    logic              resp_hit_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [31:0]       hits_q;
    logic [31:0]       misses_q;
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    age_vec_t          age_q   [SETS];

    // Datapath state (not reset)
    logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
    logic [WIDTH-1:0]  data_q [SETS][WAYS];
    logic [WIDTH-1:0]  resp_rdata_q;
    logic [WIDTH-1:0]  mem_addr_q;
    logic [WIDTH-1:0]  mem_wdata_q;
    logic              lat_we_q;
    logic [TAG_W-1:0]  lat_tag_q;
    logic [IDX_W-1:0]  lat_idx_q;
    logic [WIDTH-1:0]  lat_wdata_q;
    logic [AW-1:0]     victim_q;

    // Lookup results
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic              hit;
    logic [AW-1:0]     hit_way;
    logic              inv_found;
    logic [AW-1:0]     inv_way;
    logic [AW-1:0]     lru_way;
    logic [AW-1:0]     victim;
    logic              vic_dirty;
    logic              accept;
    logic              hit_en;
    logic              miss_en;
    logic              fill_en;
    logic              unused_off;

    // Move the touched way to MRU; ways younger than it age by one.
    function automatic age_vec_t lru_touch(input age_vec_t ages, input logic [AW-1:0] way);
        age_vec_t    r;
        logic [AW-1:0] old;
        r   = ages;
        old = ages[way];
        for (int w = 0; w < WAYS; w++) begin
            if (ages[w] < old) r[w] = ages[w] + 1'b1;
        end
        r[way] = '0;
        return r;
    endfunction

    // Saturating statistics increment.
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    assign req_tag    = req_addr_i[WIDTH-1 -: TAG_W];
    assign req_idx    = req_addr_i[OFF_W +: IDX_W];
    assign unused_off = ^req_addr_i[OFF_W-1:0];

    // Tag compare and victim selection for the incoming request's set.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
            if (!valid_q[req_idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = AW'(w);
            end
            if (age_q[req_idx][w] == AW'(WAYS - 1)) lru_way = AW'(w);
        end
        victim    = inv_found ? inv_way : lru_way;
        vic_dirty = valid_q[req_idx][victim] && dirty_q[req_idx][victim];
    end

    assign accept  = req_valid_i && (state_q == IDLE);
    assign hit_en  = accept && hit;
    assign miss_en = accept && !hit;
    assign fill_en = (state_q == REFILL) && mem_ack_i;

    // Controller FSM, line status bits, LRU ages and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            hits_q       <= '0;
            misses_q     <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
            end
        end else begin
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hit_en) begin
                        resp_valid_q   <= 1'b1;
                        resp_hit_q     <= 1'b1;
                        hits_q         <= sat_inc(hits_q);
                        age_q[req_idx] <= lru_touch(age_q[req_idx], hit_way);
                        if (req_we_i) dirty_q[req_idx][hit_way] <= 1'b1;
                    end else if (miss_en) begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= vic_dirty;
                        state_q   <= vic_dirty ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        mem_we_q <= 1'b0;
                        state_q  <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        mem_req_q                     <= 1'b0;
                        valid_q[lat_idx_q][victim_q]  <= 1'b1;
                        dirty_q[lat_idx_q][victim_q]  <= lat_we_q;
                        age_q[lat_idx_q]              <= lru_touch(age_q[lat_idx_q], victim_q);
                        resp_valid_q                  <= 1'b1;
                        misses_q                      <= sat_inc(misses_q);
                        state_q                       <= RESPOND;
                    end
                end
                RESPOND: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line data/tags, latched miss request and memory/response datapath.
    always_ff @(posedge clk) begin
        if (!rst && hit_en) begin
            resp_rdata_q <= req_we_i ? req_wdata_i : data_q[req_idx][hit_way];
            if (req_we_i) data_q[req_idx][hit_way] <= req_wdata_i;
        end
        if (!rst && miss_en) begin
            lat_we_q    <= req_we_i;
            lat_tag_q   <= req_tag;
            lat_idx_q   <= req_idx;
            lat_wdata_q <= req_wdata_i;
            victim_q    <= victim;
            mem_wdata_q <= data_q[req_idx][victim];
            mem_addr_q  <= vic_dirty ? {tag_q[req_idx][victim], req_idx, {OFF_W{1'b0}}}
                                     : {req_tag, req_idx, {OFF_W{1'b0}}};
        end
        if (!rst && (state_q == WRITEBACK) && mem_ack_i) begin
            mem_addr_q <= {lat_tag_q, lat_idx_q, {OFF_W{1'b0}}};
        end
        if (!rst && fill_en) begin
            tag_q[lat_idx_q][victim_q]  <= lat_tag_q;
            data_q[lat_idx_q][victim_q] <= lat_we_q ? lat_wdata_q : mem_rdata_i;
            resp_rdata_q                <= lat_we_q ? lat_wdata_q : mem_rdata_i;
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign resp_valid_o  = resp_valid_q;
    assign resp_hit_o    = resp_hit_q;
    assign resp_rdata_o  = resp_rdata_q;
    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign stat_hits_o   = hits_q;
    assign stat_misses_o = misses_q;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed self-checking bench for set_assoc_cache (SETS=16, WAYS=4, B=4).
module tb_set_assoc_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        resp_valid_o;
    logic        resp_hit_o;
    logic [31:0] resp_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [31:0] stat_hits_o;
    logic [31:0] stat_misses_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem_m [bit [31:0]];
    logic        op_we    [$];
    logic [31:0] op_addr  [$];
    logic [31:0] op_wdata [$];

    set_assoc_cache #(.WIDTH(32), .SETS(16), .WAYS(4), .B(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_rdata_o(resp_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stat_hits_o(stat_hits_o), .stat_misses_o(stat_misses_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One request, memory traffic served from mem_m; unknown lines read addr^0x5A5A0000.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic hit, output logic [31:0] rdata, output int lat);
        bit done;
        op_we.delete();
        op_addr.delete();
        op_wdata.delete();
        chk("ready_before_req", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        tick();
        req_valid_i = 1'b0;
        lat   = 1;
        done  = 0;
        hit   = 1'bx;
        rdata = 'x;
        for (int i = 0; i < 100 && !done; i++) begin
            mem_ack_i = 1'b0;
            if (resp_valid_o) begin
                hit   = resp_hit_o;
                rdata = resp_rdata_o;
                done  = 1;
            end else begin
                if (mem_req_o) begin
                    op_we.push_back(mem_we_o);
                    op_addr.push_back(mem_addr_o);
                    op_wdata.push_back(mem_wdata_o);
                    mem_ack_i = 1'b1;
                    if (mem_we_o) mem_m[mem_addr_o] = mem_wdata_o;
                    else mem_rdata_i = mem_m.exists(mem_addr_o) ? mem_m[mem_addr_o]
                                                                : (mem_addr_o ^ 32'h5A5A_0000);
                end
                tick();
                lat++;
            end
        end
        mem_ack_i = 1'b0;
        chk("resp_seen", {31'd0, done}, 1);
        tick();
        chk("resp_single_cycle", resp_valid_o, 0);
    endtask

    logic        h;
    logic [31:0] rd;
    int          lat;

    initial begin
        mem_m[32'h40] = 32'hDEAD_BEEF;

        // Reset state
        do_reset();
        chk("rst_ready", req_ready_o, 1);
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_resp_hit", resp_hit_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_hits", stat_hits_o, 0);
        chk("rst_misses", stat_misses_o, 0);

        // Cold read miss, then hit
        access(0, 32'h40, 0, h, rd, lat);
        chk("m1_ops", op_addr.size(), 1);
        chk("m1_op_we", op_we[0], 0);
        chk("m1_op_addr", op_addr[0], 32'h40);
        chk("m1_hit", h, 0);
        chk("m1_rdata", rd, 32'hDEAD_BEEF);
        chk("m1_lat", lat, 2);
        access(0, 32'h40, 0, h, rd, lat);
        chk("h1_hit", h, 1);
        chk("h1_lat", lat, 1);
        chk("h1_rdata", rd, 32'hDEAD_BEEF);
        chk("h1_ops", op_addr.size(), 0);
        chk("h1_hits", stat_hits_o, 1);
        chk("h1_misses", stat_misses_o, 1);

        // Dirty victim write-back
        access(1, 32'h40, 32'h1234_5678, h, rd, lat);
        chk("wh_hit", h, 1);
        chk("wh_rdata", rd, 32'h1234_5678);
        access(0, 32'h80, 0, h, rd, lat);
        chk("f80_rdata", rd, 32'h5A5A_0080);
        access(0, 32'hC0, 0, h, rd, lat);
        access(0, 32'h100, 0, h, rd, lat);
        chk("f100_hit", h, 0);
        access(0, 32'h140, 0, h, rd, lat);
        chk("wb_ops", op_addr.size(), 2);
        chk("wb_op0_we", op_we[0], 1);
        chk("wb_op0_addr", op_addr[0], 32'h40);
        chk("wb_op0_wdata", op_wdata[0], 32'h1234_5678);
        chk("wb_op1_we", op_we[1], 0);
        chk("wb_op1_addr", op_addr[1], 32'h140);
        chk("wb_rdata", rd, 32'h5A5A_0140);
        chk("wb_lat", lat, 3);
        chk("wb_hits", stat_hits_o, 2);
        chk("wb_misses", stat_misses_o, 5);

        // LRU ordering
        do_reset();
        access(0, 32'h00, 0, h, rd, lat);
        access(0, 32'h40, 0, h, rd, lat);
        access(0, 32'h80, 0, h, rd, lat);
        access(0, 32'hC0, 0, h, rd, lat);
        access(0, 32'h00, 0, h, rd, lat);
        chk("lru_rehit", h, 1);
        access(0, 32'h100, 0, h, rd, lat);
        chk("lru_evict_ops", op_addr.size(), 1);
        chk("lru_evict_addr", op_addr[0], 32'h100);
        access(0, 32'h40, 0, h, rd, lat);
        chk("lru_40_miss", h, 0);
        chk("lru_40_rdata", rd, 32'h1234_5678);
        access(0, 32'h00, 0, h, rd, lat);
        chk("lru_00_hit", h, 1);
        chk("lru_00_rdata", rd, 32'h5A5A_0000);

        // Stalled refill: outputs hold while ack is withheld
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h47;
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_mem_req", mem_req_o, 1);
            chk("stall_mem_we", mem_we_o, 0);
            chk("stall_mem_addr", mem_addr_o, 32'h44);
            chk("stall_ready", req_ready_o, 0);
            chk("stall_resp", resp_valid_o, 0);
            tick();
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hCAFE_F00D;
        tick();
        mem_ack_i = 1'b0;
        chk("stall_resp_valid", resp_valid_o, 1);
        chk("stall_resp_hit", resp_hit_o, 0);
        chk("stall_resp_rdata", resp_rdata_o, 32'hCAFE_F00D);
        chk("stall_mem_req_off", mem_req_o, 0);
        tick();
        chk("stall_resp_done", resp_valid_o, 0);
        chk("stall_ready_back", req_ready_o, 1);
        // Stray ack while idle
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk("stray_ack_resp", resp_valid_o, 0);
        chk("stray_ack_ready", req_ready_o, 1);
        access(0, 32'h44, 0, h, rd, lat);
        chk("stall_line_hit", h, 1);
        chk("stall_line_rdata", rd, 32'hCAFE_F00D);

        // Reset during REFILL
        req_valid_i = 1'b1;
        req_addr_i  = 32'h84;
        tick();
        req_valid_i = 1'b0;
        chk("rr_mem_req", mem_req_o, 1);
        chk("rr_mem_addr", mem_addr_o, 32'h84);
        rst         = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0BAD_0BAD;
        tick();
        rst = 1'b0;
        chk("rr_mem_req_off", mem_req_o, 0);
        chk("rr_resp_none0", resp_valid_o, 0);
        tick();
        mem_ack_i = 1'b0;
        chk("rr_resp_none1", resp_valid_o, 0);
        chk("rr_mem_req_idle", mem_req_o, 0);
        tick();
        chk("rr_resp_none2", resp_valid_o, 0);
        access(0, 32'h44, 0, h, rd, lat);
        chk("rr_44_miss", h, 0);
        chk("rr_44_rdata", rd, 32'h5A5A_0044);
        chk("rr_hits", stat_hits_o, 0);
        chk("rr_misses", stat_misses_o, 1);

        // Back-to-back hits
        access(0, 32'h48, 0, h, rd, lat);
        chk("b2b_fill_rdata", rd, 32'h5A5A_0048);
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h44;
        tick();
        chk("b2b_ready", req_ready_o, 1);
        chk("b2b_v0", resp_valid_o, 1);
        chk("b2b_h0", resp_hit_o, 1);
        chk("b2b_d0", resp_rdata_o, 32'h5A5A_0044);
        req_addr_i = 32'h48;
        tick();
        req_valid_i = 1'b0;
        chk("b2b_v1", resp_valid_o, 1);
        chk("b2b_h1", resp_hit_o, 1);
        chk("b2b_d1", resp_rdata_o, 32'h5A5A_0048);
        tick();
        chk("b2b_idle", resp_valid_o, 0);

        // Write hit immediately followed by read of the same line
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 32'h44;
        req_wdata_i = 32'h1111_2222;
        tick();
        req_we_i = 1'b0;
        chk("wr_v0", resp_valid_o, 1);
        chk("wr_d0", resp_rdata_o, 32'h1111_2222);
        tick();
        req_valid_i = 1'b0;
        chk("wr_v1", resp_valid_o, 1);
        chk("wr_d1", resp_rdata_o, 32'h1111_2222);
        tick();
        chk("wr_hits", stat_hits_o, 4);
        chk("wr_misses", stat_misses_o, 2);

        // Write miss allocates with the write data
        access(1, 32'h4C, 32'hABCD_0001, h, rd, lat);
        chk("wm_ops", op_addr.size(), 1);
        chk("wm_op_we", op_we[0], 0);
        chk("wm_op_addr", op_addr[0], 32'h4C);
        chk("wm_hit", h, 0);
        chk("wm_rdata", rd, 32'hABCD_0001);
        access(0, 32'h4C, 0, h, rd, lat);
        chk("wm_rehit", h, 1);
        chk("wm_rehit_rdata", rd, 32'hABCD_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
